obstacle_scheduler: RTL and testbench

- Drives the select input of the 16-to-1 obstacle mux automatically, replacing the manual switch selection.
- Sequences enabled obstacles round-robin: each runs for a frame-counted interval, followed by an idle gap.
- Shortens run time per completed round (difficulty level). Halts on game over.
- Sits between game-state logic (play_selected, game_over) and the obstacle mux, in the pclk domain.

---
 rtl/obstacle_scheduler_pkg.sv | 31 +++
 rtl/obstacle_scheduler_if.sv | 26 ++
 rtl/obstacle_scheduler_picker.sv | 39 +++
 rtl/obstacle_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/obstacle_scheduler_pkg.sv
// Shared types and constants for the obstacle scheduler: FSM state encoding,
// index/level/counter widths, the default idle mux index and a popcount helper.
package obstacle_sched_pkg;

   localparam int SEL_W   = 4;
   localparam int NUM_OBS = 16;
   localparam int LVL_W   = 3;
   localparam int CNT_W   = 12;

   // Mux input that is tied to 0 and therefore shows "no obstacle"
   localparam logic [SEL_W-1:0] DEF_IDLE_SEL = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_GAP  = 3'd1,
      ST_PICK = 3'd2,
      ST_RUN  = 3'd3,
      ST_HALT = 3'd4
   } sched_state_e;

   // Number of enabled obstacles, used to size a "round" when picks are random
   function automatic logic [4:0] popcount16(input logic [NUM_OBS-1:0] mask);
      logic [4:0] acc;
      acc = 5'd0;
      for (int i = 0; i < NUM_OBS; i++) begin
         acc = acc + {4'd0, mask[i]};
      end
      return acc;
   endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Game-state / obstacle-mux side bundle of the scheduler. The master side is
// the game logic driving frame timing, play state and the obstacle mask; the
// slave side is the scheduler producing the mux select and status.
interface obstacle_scheduler_if;
   import obstacle_sched_pkg::*;

   logic                vsync_in;
   logic                game_on;
   logic                game_over;
   logic [NUM_OBS-1:0]  enable_mask;
   logic [SEL_W-1:0]    select;
   logic                obstacle_start;
   logic                obstacle_active;
   logic [LVL_W-1:0]    level;

   modport master (
      output vsync_in, game_on, game_over, enable_mask,
      input  select, obstacle_start, obstacle_active, level
   );

   modport slave (
      input  vsync_in, game_on, game_over, enable_mask,
      output select, obstacle_start, obstacle_active, level
   );

endinterface

// File: rtl/obstacle_scheduler_picker.sv
// obs_next_picker: combinational search for the next enabled obstacle.
// The scan starts at start_idx (inclusive=1) or just after it (inclusive=0)
// and wraps 15->0. wrapped flags that the chosen index is at or behind the
// point the scan started from, i.e. a full round has been completed.
module obs_next_picker
   import obstacle_sched_pkg::*;
(
   input  logic [NUM_OBS-1:0] enable_mask,
   input  logic [SEL_W-1:0]   start_idx,
   input  logic               inclusive,
   output logic [SEL_W-1:0]   next_idx,
   output logic               found,
   output logic               wrapped
);

   logic [SEL_W-1:0] idx_s;

   // Priority scan over all 16 positions starting from the requested index
   always_comb begin
      idx_s    = start_idx;
      next_idx = start_idx;
      found    = 1'b0;
      for (int k = 0; k < NUM_OBS; k++) begin
         idx_s = start_idx + SEL_W'(k) + {{(SEL_W-1){1'b0}}, ~inclusive};
         if (!found && enable_mask[idx_s]) begin
            found    = 1'b1;
            next_idx = idx_s;
         end else begin
            found    = found;
         end
      end
      if (found) begin
         wrapped = inclusive ? (next_idx < start_idx) : (next_idx <= start_idx);
      end else begin
         wrapped = 1'b0;
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: drives the 16-to-1 obstacle mux select. Enabled
// obstacles run round-robin for a frame-counted interval separated by idle
// gaps; each completed round raises the difficulty level, which shortens the
// run length down to a floor. game_over freezes everything in HALT.
// Optional build macro OBSTACLE_SCHED_RANDOM_EN: the search start comes from a
// free-running 16-bit Galois LFSR and the level rises once per
// popcount(enable_mask) picks. Without it no LFSR logic exists.
module obstacle_scheduler
   import obstacle_sched_pkg::*;
#(
   parameter int               RUN_FRAMES     = 600,
   parameter int               GAP_FRAMES     = 60,
   parameter int               RUN_STEP       = 30,
   parameter int               MIN_RUN_FRAMES = 240,
   parameter int               MAX_LEVEL      = 7,
   parameter logic [SEL_W-1:0] IDLE_SEL       = DEF_IDLE_SEL
)(
   input  logic                 pclk,
   input  logic                 rst,
   obstacle_scheduler_if.slave  bus
);

   localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEVEL);
   localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

   // Run length for a level, clamped at the floor without unsigned underflow
   function automatic logic [CNT_W-1:0] run_len_f(input logic [LVL_W-1:0] lvl);
      logic [15:0] dec_v;
      logic [15:0] base_v;
      logic [15:0] raw_v;
      dec_v  = 16'(lvl) * 16'(RUN_STEP);
      base_v = 16'(RUN_FRAMES);
      if (base_v > dec_v) begin
         raw_v = base_v - dec_v;
      end else begin
         raw_v = 16'd0;
      end
      if (raw_v < 16'(MIN_RUN_FRAMES)) begin
         raw_v = 16'(MIN_RUN_FRAMES);
      end else begin
         raw_v = raw_v;
      end
      return raw_v[CNT_W-1:0];
   endfunction

   sched_state_e      state_r, state_nx_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
   logic [SEL_W-1:0]  cur_r, cur_nx_s;
   logic              first_r, first_nx_s;
   logic [LVL_W-1:0]  level_r, level_nx_s;
   logic [SEL_W-1:0]  select_r, select_nx_s;
   logic              active_r, active_nx_s;
   logic              start_r, start_nx_s;
   logic              vsync_q_r;
   logic              tick_s;

   logic [SEL_W-1:0]  pick_start_s;
   logic              pick_incl_s;
   logic [SEL_W-1:0]  pick_idx_s;
   logic              pick_found_s;
   logic              pick_wrapped_s;
   logic              round_s;
   logic [LVL_W-1:0]  level_pick_s;

   assign tick_s = bus.vsync_in & ~vsync_q_r;

   obs_next_picker u_picker (
      .enable_mask (bus.enable_mask),
      .start_idx   (pick_start_s),
      .inclusive   (pick_incl_s),
      .next_idx    (pick_idx_s),
      .found       (pick_found_s),
      .wrapped     (pick_wrapped_s)
   );

`ifdef OBSTACLE_SCHED_RANDOM_EN
   logic [15:0] lfsr_r;
   logic [4:0]  pick_cnt_r, pick_cnt_nx_s;
   logic        unused_wrap_s;

   // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1
   always_ff @(posedge pclk) begin
      if (rst) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
      end
   end

   // Picks made since the last level increment
   always_ff @(posedge pclk) begin
      if (rst) begin
         pick_cnt_r <= 5'd0;
      end else begin
         pick_cnt_r <= pick_cnt_nx_s;
      end
   end

   assign pick_start_s  = lfsr_r[SEL_W-1:0];
   assign pick_incl_s   = 1'b1;
   assign round_s       = !first_r && ((pick_cnt_r + 5'd1) >= popcount16(bus.enable_mask));
   assign unused_wrap_s = pick_wrapped_s;
`else
   assign pick_start_s = first_r ? {SEL_W{1'b0}} : cur_r;
   assign pick_incl_s  = first_r;
   assign round_s      = !first_r && pick_wrapped_s;
`endif

   assign level_pick_s = (round_s && (level_r < MAX_LVL)) ? (level_r + LVL_ONE) : level_r;

   // Frame tick edge detector on vsync
   always_ff @(posedge pclk) begin
      if (rst) begin
         vsync_q_r <= 1'b0;
      end else begin
         vsync_q_r <= bus.vsync_in;
      end
   end

   // Next-state and next-output logic; priority game_over > !game_on > events
   always_comb begin
      state_nx_s  = state_r;
      cnt_nx_s    = cnt_r;
      cur_nx_s    = cur_r;
      first_nx_s  = first_r;
      level_nx_s  = level_r;
      select_nx_s = select_r;
      active_nx_s = active_r;
      start_nx_s  = 1'b0;
`ifdef OBSTACLE_SCHED_RANDOM_EN
      pick_cnt_nx_s = pick_cnt_r;
`endif
      if ((state_r != ST_IDLE) && bus.game_over) begin
         state_nx_s  = ST_HALT;
         select_nx_s = IDLE_SEL;
         active_nx_s = 1'b0;
      end else if (!bus.game_on) begin
         state_nx_s  = ST_IDLE;
         cnt_nx_s    = {CNT_W{1'b0}};
         first_nx_s  = 1'b1;
         level_nx_s  = {LVL_W{1'b0}};
         select_nx_s = IDLE_SEL;
         active_nx_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!bus.game_over) begin
                  state_nx_s = ST_GAP;
                  cnt_nx_s   = GAP_CNT;
                  first_nx_s = 1'b1;
                  level_nx_s = {LVL_W{1'b0}};
`ifdef OBSTACLE_SCHED_RANDOM_EN
                  pick_cnt_nx_s = 5'd0;
`endif
               end else begin
                  state_nx_s = ST_IDLE;
               end
               select_nx_s = IDLE_SEL;
               active_nx_s = 1'b0;
            end
            ST_GAP: begin
               select_nx_s = IDLE_SEL;
               active_nx_s = 1'b0;
               if (tick_s) begin
                  if (cnt_r <= CNT_ONE) begin
                     cnt_nx_s   = {CNT_W{1'b0}};
                     state_nx_s = ST_PICK;
                  end else begin
                     cnt_nx_s = cnt_r - CNT_ONE;
                  end
               end else begin
                  cnt_nx_s = cnt_r;
               end
            end
            ST_PICK: begin
               if (!pick_found_s) begin
                  state_nx_s = ST_GAP;
                  cnt_nx_s   = GAP_CNT;
               end else begin
                  state_nx_s  = ST_RUN;
                  cur_nx_s    = pick_idx_s;
                  first_nx_s  = 1'b0;
                  level_nx_s  = level_pick_s;
                  cnt_nx_s    = run_len_f(level_pick_s);
                  select_nx_s = pick_idx_s;
                  active_nx_s = 1'b1;
                  start_nx_s  = 1'b1;
`ifdef OBSTACLE_SCHED_RANDOM_EN
                  pick_cnt_nx_s = round_s ? 5'd0 : (pick_cnt_r + 5'd1);
`endif
               end
            end
            ST_RUN: begin
               if (tick_s) begin
                  if (cnt_r <= CNT_ONE) begin
                     state_nx_s  = ST_GAP;
                     cnt_nx_s    = GAP_CNT;
                     select_nx_s = IDLE_SEL;
                     active_nx_s = 1'b0;
                  end else begin
                     cnt_nx_s = cnt_r - CNT_ONE;
                  end
               end else begin
                  cnt_nx_s = cnt_r;
               end
            end
            ST_HALT: begin
               select_nx_s = IDLE_SEL;
               active_nx_s = 1'b0;
            end
            default: begin
               state_nx_s  = ST_IDLE;
               cnt_nx_s    = {CNT_W{1'b0}};
               first_nx_s  = 1'b1;
               level_nx_s  = {LVL_W{1'b0}};
               select_nx_s = IDLE_SEL;
               active_nx_s = 1'b0;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         cur_r    <= {SEL_W{1'b0}};
         first_r  <= 1'b1;
         level_r  <= {LVL_W{1'b0}};
         select_r <= IDLE_SEL;
         active_r <= 1'b0;
         start_r  <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         cnt_r    <= cnt_nx_s;
         cur_r    <= cur_nx_s;
         first_r  <= first_nx_s;
         level_r  <= level_nx_s;
         select_r <= select_nx_s;
         active_r <= active_nx_s;
         start_r  <= start_nx_s;
      end
   end

   assign bus.select          = select_r;
   assign bus.obstacle_active = active_r;
   assign bus.obstacle_start  = start_r;
   assign bus.level           = level_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with short frame counts:
// RUN_FRAMES=4, GAP_FRAMES=2, RUN_STEP=1, MIN_RUN_FRAMES=2, MAX_LEVEL=3.
// Observed tuple is {select, obstacle_active, level}.
module tb_obstacle_scheduler;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;
   int   starts      = 0;

   obstacle_scheduler_if bus();

   obstacle_scheduler #(
      .RUN_FRAMES     (4),
      .GAP_FRAMES     (2),
      .RUN_STEP       (1),
      .MIN_RUN_FRAMES (2),
      .MAX_LEVEL      (3)
   ) dut (
      .pclk (clk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Count obstacle_start pulses (each is high for one cycle)
   always @(posedge clk) begin
      if (bus.obstacle_start === 1'b1) starts++;
   end

   function automatic logic [7:0] obs();
      return {bus.select, bus.obstacle_active, bus.level};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.game_on = 1'b0; bus.game_over = 1'b0; bus.vsync_in = 1'b0; bus.enable_mask = 16'h0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic go(input logic [15:0] mask);
      bus.enable_mask = mask;
      bus.game_on = 1'b1;
      @(negedge clk);
   endtask

   // n vsync pulses, each followed by enough cycles for PICK->RUN to settle
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); bus.vsync_in = 1'b1;
         @(negedge clk); bus.vsync_in = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.game_on = 1'b1; bus.game_over = 1'b0; bus.vsync_in = 1'b0; bus.enable_mask = 16'h0003;
      repeat (3) @(negedge clk);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd0}) begin $display("FAIL reset_outputs: got %h want %h", obs(), {4'd15, 1'b0, 3'd0}); miscompares++; end
      vectors++; if (bus.obstacle_start !== 1'b0) begin $display("FAIL reset_start: got %b want 0", bus.obstacle_start); miscompares++; end
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      int s0;
      do_reset(); s0 = starts; go(16'h0003);
      tick(2);
      vectors++; if (obs() !== {4'd0, 1'b1, 3'd0}) begin $display("FAIL rr_pick0: got %h want %h", obs(), {4'd0, 1'b1, 3'd0}); miscompares++; end
      vectors++; if (starts !== s0 + 1) begin $display("FAIL rr_start_once: got %0d want %0d", starts - s0, 1); miscompares++; end
      tick(3);
      vectors++; if (obs() !== {4'd0, 1'b1, 3'd0}) begin $display("FAIL rr_run0_hold: got %h want %h", obs(), {4'd0, 1'b1, 3'd0}); miscompares++; end
      tick(1);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd0}) begin $display("FAIL rr_run0_end: got %h want %h", obs(), {4'd15, 1'b0, 3'd0}); miscompares++; end
      tick(1);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd0}) begin $display("FAIL rr_gap_hold: got %h want %h", obs(), {4'd15, 1'b0, 3'd0}); miscompares++; end
      tick(1);
      vectors++; if (obs() !== {4'd1, 1'b1, 3'd0}) begin $display("FAIL rr_pick1: got %h want %h", obs(), {4'd1, 1'b1, 3'd0}); miscompares++; end
      tick(3);
      vectors++; if (obs() !== {4'd1, 1'b1, 3'd0}) begin $display("FAIL rr_run1_hold: got %h want %h", obs(), {4'd1, 1'b1, 3'd0}); miscompares++; end
      tick(1); tick(2);
      vectors++; if (obs() !== {4'd0, 1'b1, 3'd1}) begin $display("FAIL rr_wrap_level1: got %h want %h", obs(), {4'd0, 1'b1, 3'd1}); miscompares++; end
      tick(2);
      vectors++; if (obs() !== {4'd0, 1'b1, 3'd1}) begin $display("FAIL rr_run3_hold: got %h want %h", obs(), {4'd0, 1'b1, 3'd1}); miscompares++; end
      tick(1);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd1}) begin $display("FAIL rr_run3_end: got %h want %h", obs(), {4'd15, 1'b0, 3'd1}); miscompares++; end
      vectors++; if (starts !== s0 + 3) begin $display("FAIL rr_start_count: got %0d want %0d", starts - s0, 3); miscompares++; end
   endtask

   task automatic test_level_saturate();
      logic [2:0] lvl;
      int run;
      do_reset(); go(16'h0001);
      tick(2);
      for (int r = 0; r < 5; r++) begin
         lvl = (r > 3) ? 3'd3 : 3'(r);
         run = (4 - int'(lvl) < 2) ? 2 : 4 - int'(lvl);
         vectors++; if (obs() !== {4'd0, 1'b1, lvl}) begin $display("FAIL sat_pick_r%0d: got %h want %h", r, obs(), {4'd0, 1'b1, lvl}); miscompares++; end
         tick(run - 1);
         vectors++; if (obs() !== {4'd0, 1'b1, lvl}) begin $display("FAIL sat_hold_r%0d: got %h want %h", r, obs(), {4'd0, 1'b1, lvl}); miscompares++; end
         tick(1);
         vectors++; if (obs() !== {4'd15, 1'b0, lvl}) begin $display("FAIL sat_end_r%0d: got %h want %h", r, obs(), {4'd15, 1'b0, lvl}); miscompares++; end
         tick(2);
      end
   endtask

   task automatic test_empty_mask();
      int s0;
      do_reset(); s0 = starts; go(16'h0000);
      tick(2);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd0}) begin $display("FAIL empty_gap1: got %h want %h", obs(), {4'd15, 1'b0, 3'd0}); miscompares++; end
      tick(2);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd0}) begin $display("FAIL empty_gap2: got %h want %h", obs(), {4'd15, 1'b0, 3'd0}); miscompares++; end
      vectors++; if (starts !== s0) begin $display("FAIL empty_no_start: got %0d want 0", starts - s0); miscompares++; end
      bus.enable_mask = 16'h0004;
      tick(2);
      vectors++; if (obs() !== {4'd2, 1'b1, 3'd0}) begin $display("FAIL empty_then_pick2: got %h want %h", obs(), {4'd2, 1'b1, 3'd0}); miscompares++; end
      vectors++; if (starts !== s0 + 1) begin $display("FAIL empty_then_start: got %0d want 1", starts - s0); miscompares++; end
   endtask

   task automatic test_game_over();
      do_reset(); go(16'h0003);
      tick(2); tick(4); tick(2); tick(4); tick(2); tick(3); tick(2);
      vectors++; if (obs() !== {4'd1, 1'b1, 3'd1}) begin $display("FAIL go_pre_run1: got %h want %h", obs(), {4'd1, 1'b1, 3'd1}); miscompares++; end
      @(negedge clk); bus.vsync_in = 1'b1; bus.game_over = 1'b1;
      @(negedge clk);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd1}) begin $display("FAIL go_halt: got %h want %h", obs(), {4'd15, 1'b0, 3'd1}); miscompares++; end
      bus.vsync_in = 1'b0; bus.game_over = 1'b0;
      tick(3);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd1}) begin $display("FAIL go_halt_hold: got %h want %h", obs(), {4'd15, 1'b0, 3'd1}); miscompares++; end
      bus.game_on = 1'b0;
      @(negedge clk);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd0}) begin $display("FAIL go_to_idle: got %h want %h", obs(), {4'd15, 1'b0, 3'd0}); miscompares++; end
   endtask

   task automatic test_reset_mid_run();
      do_reset(); go(16'h0003);
      tick(2); tick(4); tick(2);
      vectors++; if (obs() !== {4'd1, 1'b1, 3'd0}) begin $display("FAIL rst_pre_run1: got %h want %h", obs(), {4'd1, 1'b1, 3'd0}); miscompares++; end
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd0}) begin $display("FAIL rst_mid_run: got %h want %h", obs(), {4'd15, 1'b0, 3'd0}); miscompares++; end
      rst = 1'b0;
      @(negedge clk);
      tick(2);
      vectors++; if (obs() !== {4'd0, 1'b1, 3'd0}) begin $display("FAIL rst_first_pick: got %h want %h", obs(), {4'd0, 1'b1, 3'd0}); miscompares++; end
   endtask

   task automatic test_mask_change();
      do_reset(); go(16'h0003);
      tick(2);
      vectors++; if (obs() !== {4'd0, 1'b1, 3'd0}) begin $display("FAIL mc_pick0: got %h want %h", obs(), {4'd0, 1'b1, 3'd0}); miscompares++; end
      bus.enable_mask = 16'h0002;
      tick(3);
      vectors++; if (obs() !== {4'd0, 1'b1, 3'd0}) begin $display("FAIL mc_run0_full: got %h want %h", obs(), {4'd0, 1'b1, 3'd0}); miscompares++; end
      tick(1);
      vectors++; if (obs() !== {4'd15, 1'b0, 3'd0}) begin $display("FAIL mc_run0_end: got %h want %h", obs(), {4'd15, 1'b0, 3'd0}); miscompares++; end
      tick(2);
      vectors++; if (obs() !== {4'd1, 1'b1, 3'd0}) begin $display("FAIL mc_pick1_no_level: got %h want %h", obs(), {4'd1, 1'b1, 3'd0}); miscompares++; end
      tick(4); tick(2);
      vectors++; if (obs() !== {4'd1, 1'b1, 3'd1}) begin $display("FAIL mc_sole_wrap: got %h want %h", obs(), {4'd1, 1'b1, 3'd1}); miscompares++; end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_level_saturate();
      test_empty_mask();
      test_game_over();
      test_reset_mid_run();
      test_mask_change();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
